// File: rtl/fetch_decode_buffer.sv
// fetch_decode_buffer
//   IF/ID pipeline register. It captures each fetched 16-bit word with its PC.
//   When the first word has IMM_FLAG_BIT set, the next fetched word becomes that
//   instruction's immediate. The opcode word and its immediate leave as one
//   decode packet.
//   Flush takes priority over stall. Stall takes priority over normal capture.
//
// Ports
//   i_clk       clock, rising edge
//   i_reset     asynchronous active-high reset
//   i_instr     fetched instruction-memory word
//   i_pc        address of i_instr
//   i_valid     i_instr/i_pc carry a real fetched word this cycle
//   i_stall     hold all state (hazard unit)
//   i_flush     squash buffered/partial instruction (branch taken / interrupt)
//   o_instr     opcode word of the decode packet
//   o_imm       immediate word, 0 when o_has_imm=0
//   o_pc        PC of the opcode word
//   o_has_imm   packet carries an immediate
//   o_valid     packet complete, decode it this cycle
//   o_wait_imm  opcode word held, awaiting its immediate word
module fetch_decode_buffer #(
  parameter int INSTR_WIDTH  = 16,
  parameter int PC_WIDTH     = 32,
  parameter int IMM_FLAG_BIT = 0
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  input  logic [PC_WIDTH-1:0]    i_pc,
  input  logic                   i_valid,
  input  logic                   i_stall,
  input  logic                   i_flush,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [INSTR_WIDTH-1:0] o_imm,
  output logic [PC_WIDTH-1:0]    o_pc,
  output logic                   o_has_imm,
  output logic                   o_valid,
  output logic                   o_wait_imm
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_IMM = 1'b1
  } state_t;

  state_t state;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      o_instr    <= '0;
      o_imm      <= '0;
      o_pc       <= '0;
      o_has_imm  <= 1'b0;
      o_valid    <= 1'b0;
      o_wait_imm <= 1'b0;
    end else if (i_flush) begin
      // Flush discards the word presented this cycle and leaves a NOP packet.
      state      <= IDLE;
      o_instr    <= '0;
      o_imm      <= '0;
      o_pc       <= '0;
      o_has_imm  <= 1'b0;
      o_valid    <= 1'b0;
      o_wait_imm <= 1'b0;
    end else if (!i_stall) begin
      unique case (state)
        IDLE: begin
          if (!i_valid) begin
            o_valid <= 1'b0;
          end else if (i_instr[IMM_FLAG_BIT]) begin
            o_instr    <= i_instr;
            o_pc       <= i_pc;
            o_imm      <= '0;
            o_has_imm  <= 1'b0;
            o_valid    <= 1'b0;
            o_wait_imm <= 1'b1;
            state      <= WAIT_IMM;
          end else begin
            o_instr   <= i_instr;
            o_pc      <= i_pc;
            o_imm     <= '0;
            o_has_imm <= 1'b0;
            o_valid   <= 1'b1;
          end
        end
        WAIT_IMM: begin
          if (!i_valid) begin
            o_valid <= 1'b0;
          end else begin
            // The immediate word's flag bit is data, and its PC is not used.
            o_imm      <= i_instr;
            o_has_imm  <= 1'b1;
            o_valid    <= 1'b1;
            o_wait_imm <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          o_wait_imm <= 1'b0;
          o_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Testbench for fetch_decode_buffer. It runs directed scenarios and then random
// traffic. Every output is compared with a packet-level reference model.
module tb_fetch_decode_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_instr;
  logic [31:0] i_pc;
  logic        i_valid, i_stall, i_flush;
  logic [15:0] o_instr, o_imm;
  logic [31:0] o_pc;
  logic        o_has_imm, o_valid, o_wait_imm;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model state: the current decode packet and any held opcode word.
  logic [15:0] m_instr, m_imm;
  logic [31:0] m_pc;
  logic        m_has_imm, m_valid, m_pending;

  fetch_decode_buffer #(
    .INSTR_WIDTH (16),
    .PC_WIDTH    (32),
    .IMM_FLAG_BIT(0)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_instr   (i_instr),
    .i_pc      (i_pc),
    .i_valid   (i_valid),
    .i_stall   (i_stall),
    .i_flush   (i_flush),
    .o_instr   (o_instr),
    .o_imm     (o_imm),
    .o_pc      (o_pc),
    .o_has_imm (o_has_imm),
    .o_valid   (o_valid),
    .o_wait_imm(o_wait_imm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
  endtask

  task automatic model_clear();
    m_instr = '0; m_imm = '0; m_pc = '0;
    m_has_imm = 0; m_valid = 0; m_pending = 0;
  endtask

  // Apply one rising edge to the model, using the packet-assembly rules.
  task automatic model_edge(input logic [15:0] w, input logic [31:0] pc,
                            input logic v, input logic s, input logic f);
    if (f) model_clear();
    else if (s) ;
    else if (!v) m_valid = 0;
    else if (m_pending) begin
      m_imm = w; m_has_imm = 1; m_valid = 1; m_pending = 0;
    end else begin
      m_instr = w; m_pc = pc; m_imm = '0; m_has_imm = 0;
      m_pending = w[0];
      m_valid = !w[0];
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".instr"},    {16'h0, o_instr},   {16'h0, m_instr});
    check({tag, ".imm"},      {16'h0, o_imm},     {16'h0, m_imm});
    check({tag, ".pc"},       o_pc,               m_pc);
    check({tag, ".has_imm"},  {31'h0, o_has_imm}, {31'h0, m_has_imm});
    check({tag, ".valid"},    {31'h0, o_valid},   {31'h0, m_valid});
    check({tag, ".wait_imm"}, {31'h0, o_wait_imm},{31'h0, m_pending});
  endtask

  // Drive one cycle, clock it, then compare #1 after the edge.
  task automatic step(input string tag, input logic [15:0] w, input logic [31:0] pc,
                      input logic v, input logic s, input logic f);
    i_instr = w; i_pc = pc; i_valid = v; i_stall = s; i_flush = f;
    @(posedge clk);
    model_edge(w, pc, v, s, f);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1; i_instr = '0; i_pc = '0; i_valid = 0; i_stall = 0; i_flush = 0;
    model_clear();
    #12;
    check_all("reset");
    rst = 0;

    // Single-word instruction
    step("single", 16'h1234, 32'h10, 1, 0, 0);
    check("single.lit_valid", {31'h0, o_valid}, 32'h1);
    check("single.lit_instr", {16'h0, o_instr}, 32'h1234);

    // Two-word instruction
    step("two.w1", 16'h5001, 32'h20, 1, 0, 0);
    check("two.w1.lit_wait", {31'h0, o_wait_imm}, 32'h1);
    step("two.w2", 16'hABCD, 32'h21, 1, 0, 0);
    check("two.w2.lit_imm", {16'h0, o_imm}, 32'hABCD);
    check("two.w2.lit_pc", o_pc, 32'h20);

    // Immediate word with its flag bit set, then a single-word instruction
    step("immflag.w1", 16'h5001, 32'h30, 1, 0, 0);
    step("immflag.w2", 16'hFFFF, 32'h31, 1, 0, 0);
    check("immflag.lit_imm", {16'h0, o_imm}, 32'hFFFF);
    step("immflag.next", 16'h0002, 32'h32, 1, 0, 0);
    check("immflag.next.lit_wait", {31'h0, o_wait_imm}, 32'h0);

    // Stall while holding a valid packet
    step("stall.pkt", 16'h1234, 32'h40, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("stall.hold", 16'h0100 + 16'(i * 2), 32'h50 + 32'(i), 1, 1, 0);
      check("stall.lit_instr", {16'h0, o_instr}, 32'h1234);
    end
    step("stall.release", 16'h0AA2, 32'h60, 1, 0, 0);
    check("stall.release.lit", {16'h0, o_instr}, 32'h0AA2);

    // Flush in WAIT_IMM, with stall and valid both asserted
    step("flush.w1", 16'h5001, 32'h70, 1, 0, 0);
    step("flush.do", 16'h7777, 32'h71, 1, 1, 1);
    check("flush.lit_pc", o_pc, 32'h0);
    step("flush.next", 16'h0040, 32'h72, 1, 0, 0);
    check("flush.next.lit_valid", {31'h0, o_valid}, 32'h1);

    // Asynchronous reset between edges while in WAIT_IMM
    step("areset.w1", 16'h5001, 32'h80, 1, 0, 0);
    rst = 1;
    #1;
    model_clear();
    check_all("areset.now");
    #1 rst = 0;
    step("areset.a", 16'h1235, 32'h90, 1, 0, 0);
    step("areset.b", 16'h00EE, 32'h91, 1, 0, 0);
    check("areset.b.lit_has", {31'h0, o_has_imm}, 32'h1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step("rand", 16'($urandom), $urandom,
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 6) == 0),
           ($urandom_range(0, 19) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
